// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor: batch error statistics for a signed 8x8 approximate multiplier.
// For each accepted beat it forms the exact product and |approx - exact|. Over a batch of
// N beats it accumulates the saturating error sum, the worst-case error, the count of
// erroneous samples and the count of samples.
// Optional feature: define APPROX_ERR_BIAS_EN to add err_bias, a signed saturating sum of
// (approx - exact).
module approx_mult_err_monitor #(
  parameter int unsigned SUM_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_samples,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              op_a,
  input  logic [7:0]              op_b,
  input  logic [15:0]             approx_p,
  output logic                    busy,
  output logic                    done,
  output logic [SUM_W-1:0]        err_sum,
  output logic                    err_sum_sat,
  output logic [16:0]             err_max,
  output logic [CNT_W-1:0]        err_cnt,
`ifdef APPROX_ERR_BIAS_EN
  output logic signed [SUM_W-1:0] err_bias,
`endif
  output logic [CNT_W-1:0]        sample_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] n_q, acc_cnt_q, acc_inc;
  logic             accept, start_acc, acc_last;

  // S1: exact product and sign-extended approximate product.
  logic               s1_valid_q;
  logic signed [16:0] s1_exact_q, s1_approx_q;
  logic signed [15:0] a_ext, b_ext, prod;

  // S2: signed difference and its magnitude.
  logic               s2_valid_q;
  logic signed [16:0] s2_diff_q, diff;
  logic [16:0]        s2_abs_q, abs_err;

  logic [SUM_W-1:0] err_sum_q, err_sum_d;
  logic [SUM_W:0]   sum_ext;
  logic             err_sum_sat_q;
  logic [16:0]      err_max_q;
  logic [CNT_W-1:0] err_cnt_q, sample_cnt_q;

  assign accept    = in_valid & in_ready;
  assign start_acc = (state_q == StIdle) & start;
  assign acc_inc   = acc_cnt_q + CNT_W'(1);
  assign acc_last  = (acc_inc == n_q);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (num_samples == '0) ? StDone : StRun;
      StRun:   if (accept && acc_last) state_d = StDrain;
      StDrain: if (!s1_valid_q && !s2_valid_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; leaving RUN on the last accept is what drops in_ready.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      StRun: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDrain: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Batch length latch and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      acc_cnt_q <= '0;
    end else if (start_acc) begin
      n_q       <= num_samples;
      acc_cnt_q <= '0;
    end else if (accept) begin
      acc_cnt_q <= acc_inc;
    end
  end

  assign a_ext = {{8{op_a[7]}}, op_a};
  assign b_ext = {{8{op_b[7]}}, op_b};
  assign prod  = a_ext * b_ext;

  // S1 register: the 8x8 signed product always fits 16 bits (max 16384).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_exact_q  <= {prod[15], prod};
        s1_approx_q <= {approx_p[15], approx_p};
      end
    end
  end

  assign diff    = s1_approx_q - s1_exact_q;
  assign abs_err = diff[16] ? $unsigned(-diff) : $unsigned(diff);

  // S2 register: |diff| peaks at 49152, so 17 bits never overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_diff_q  <= '0;
      s2_abs_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_diff_q <= diff;
        s2_abs_q  <= abs_err;
      end
    end
  end

  assign sum_ext   = {1'b0, err_sum_q} + (SUM_W+1)'(s2_abs_q);
  assign err_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];

  // Accumulators: cleared on reset and on an accepted start, updated from S2.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      err_sum_q     <= '0;
      err_sum_sat_q <= 1'b0;
      err_max_q     <= '0;
      err_cnt_q     <= '0;
      sample_cnt_q  <= '0;
    end else if (s2_valid_q) begin
      err_sum_q    <= err_sum_d;
      sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      if (sum_ext[SUM_W])       err_sum_sat_q <= 1'b1;
      if (s2_abs_q > err_max_q) err_max_q     <= s2_abs_q;
      if (s2_abs_q != '0)       err_cnt_q     <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_sum     = err_sum_q;
  assign err_sum_sat = err_sum_sat_q;
  assign err_max     = err_max_q;
  assign err_cnt     = err_cnt_q;
  assign sample_cnt  = sample_cnt_q;

`ifdef APPROX_ERR_BIAS_EN
  logic signed [SUM_W-1:0] err_bias_q, err_bias_d;
  logic signed [SUM_W:0]   bias_ext;

  assign bias_ext = (SUM_W+1)'(err_bias_q) + (SUM_W+1)'(s2_diff_q);

  // Clamp when the extra sign bit disagrees with the result's sign bit.
  always_comb begin
    err_bias_d = bias_ext[SUM_W-1:0];
    if (bias_ext[SUM_W] != bias_ext[SUM_W-1]) begin
      err_bias_d = bias_ext[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
    end
  end

  // Signed bias accumulator.
  always_ff @(posedge clk) begin
    if (rst || start_acc) err_bias_q <= '0;
    else if (s2_valid_q)  err_bias_q <= err_bias_d;
  end

  assign err_bias = err_bias_q;
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Self-checking bench for approx_mult_err_monitor: a 32-bit and a 16-bit err_sum instance
// share stimulus; batch results are compared against a queue-based reference model.
module tb_approx_mult_err_monitor;

  localparam int CW = 16;
  localparam longint Max32 = 64'd4294967295;
  localparam longint Max16 = 64'd65535;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } beat_t;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [CW-1:0] num_samples;
  logic [7:0] op_a, op_b;
  logic [15:0] approx_p;

  logic in_ready, busy, done, sat;
  logic [31:0] err_sum;
  logic [16:0] err_max;
  logic [CW-1:0] err_cnt, sample_cnt;

  logic in_ready_n, busy_n, done_n, sat_n;
  logic [15:0] err_sum_n;
  logic [16:0] err_max_n;
  logic [CW-1:0] err_cnt_n, sample_cnt_n;

`ifdef APPROX_ERR_BIAS_EN
  logic signed [31:0] err_bias;
  logic signed [15:0] err_bias_n;
`endif

  int total_cnt = 0;
  int bad_cnt = 0;

  beat_t stim_q[$];
  beat_t acc_q[$];

  always #5 clk = ~clk;

  approx_mult_err_monitor #(.SUM_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
    .approx_p(approx_p), .busy(busy), .done(done), .err_sum(err_sum),
    .err_sum_sat(sat), .err_max(err_max), .err_cnt(err_cnt),
`ifdef APPROX_ERR_BIAS_EN
    .err_bias(err_bias),
`endif
    .sample_cnt(sample_cnt)
  );

  approx_mult_err_monitor #(.SUM_W(16), .CNT_W(CW)) dut_n (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_n), .op_a(op_a), .op_b(op_b),
    .approx_p(approx_p), .busy(busy_n), .done(done_n), .err_sum(err_sum_n),
    .err_sum_sat(sat_n), .err_max(err_max_n), .err_cnt(err_cnt_n),
`ifdef APPROX_ERR_BIAS_EN
    .err_bias(err_bias_n),
`endif
    .sample_cnt(sample_cnt_n)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int beat_diff(input beat_t bt);
    return int'($signed(bt.p)) - int'($signed(bt.a)) * int'($signed(bt.b));
  endfunction

  function automatic longint sat_add(input longint acc, input longint d, input int w);
    longint s  = acc + d;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    int ex, ap;
    bt.a = 8'($urandom);
    bt.b = 8'($urandom);
    ex = int'($signed(bt.a)) * int'($signed(bt.b));
    case ($urandom_range(0, 3))
      0:       ap = ex;
      1:       ap = ex + int'($urandom_range(0, 16)) - 8;
      2:       ap = int'($signed(16'($urandom)));
      default: ap = ex + int'($urandom_range(0, 4000)) - 2000;
    endcase
    bt.p = 16'(ap);
    return bt;
  endfunction

  function automatic beat_t mk(input int a, input int b, input int p);
    beat_t bt;
    bt.a = 8'(a);
    bt.b = 8'(b);
    bt.p = 16'(p);
    return bt;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, err_sum, 0);
    chk({tag, "_sat"}, sat, 0);
    chk({tag, "_max"}, err_max, 0);
    chk({tag, "_errcnt"}, err_cnt, 0);
    chk({tag, "_samples"}, sample_cnt, 0);
    chk({tag, "_n_in_ready"}, in_ready_n, 0);
    chk({tag, "_n_busy"}, busy_n, 0);
    chk({tag, "_n_sum"}, err_sum_n, 0);
    chk({tag, "_n_samples"}, sample_cnt_n, 0);
`ifdef APPROX_ERR_BIAS_EN
    chk({tag, "_bias"}, err_bias, 0);
    chk({tag, "_n_bias"}, err_bias_n, 0);
`endif
  endtask

  // Reference: statistics of the accepted beats, computed directly from the error definition.
  task automatic check_results(input string tag);
    longint tot = 0, mx = 0, ne = 0, b32 = 0, b16 = 0, d, a;
    foreach (acc_q[i]) begin
      d = longint'(beat_diff(acc_q[i]));
      a = (d < 0) ? -d : d;
      tot += a;
      if (a > mx) mx = a;
      if (a != 0) ne++;
      b32 = sat_add(b32, d, 32);
      b16 = sat_add(b16, d, 16);
    end
    chk({tag, "_sum"}, err_sum, (tot > Max32) ? Max32 : tot);
    chk({tag, "_sat"}, sat, (tot > Max32) ? 1 : 0);
    chk({tag, "_max"}, err_max, mx);
    chk({tag, "_errcnt"}, err_cnt, ne);
    chk({tag, "_samples"}, sample_cnt, acc_q.size());
    chk({tag, "_n_sum"}, err_sum_n, (tot > Max16) ? Max16 : tot);
    chk({tag, "_n_sat"}, sat_n, (tot > Max16) ? 1 : 0);
    chk({tag, "_n_max"}, err_max_n, mx);
    chk({tag, "_n_errcnt"}, err_cnt_n, ne);
    chk({tag, "_n_samples"}, sample_cnt_n, acc_q.size());
`ifdef APPROX_ERR_BIAS_EN
    chk({tag, "_bias"}, err_bias, b32);
    chk({tag, "_n_bias"}, err_bias_n, b16);
`else
    if (b32 + b16 > Max32) $display("note: large bias %0d", b32);
`endif
  endtask

  // vmode: 0 = in_valid always high, 1 = random gaps, 2 = 7-entry pattern (bit 0 first).
  // abort_at > 0 asserts rst once that many beats have been accepted.
  task automatic run_batch(input string tag, input int n, input int vmode,
                           input logic [6:0] pat, input bit poke, input int abort_at);
    int acc = 0;
    int cyc = 0;
    int idx, rdy, dn;
    beat_t bt;
    acc_q.delete();
    @(negedge clk);
    start = 1'b1;
    num_samples = CW'(n);
    @(negedge clk);
    start = 1'b0;
    num_samples = CW'($urandom);
    while (acc < n && cyc < 300) begin
      if (abort_at > 0 && acc == abort_at) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_zero({tag, "_abort"});
        dn = 0;
        repeat (6) begin
          @(negedge clk);
          if (done) dn++;
        end
        chk({tag, "_abort_no_done"}, dn, 0);
        acc_q.delete();
        return;
      end
      bt = (stim_q.size() != 0) ? stim_q[0] : rand_beat();
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = ($urandom_range(0, 3) != 0);
        default: in_valid = (cyc < 7) ? pat[cyc] : 1'b0;
      endcase
      op_a = bt.a;
      op_b = bt.b;
      approx_p = bt.p;
      start = poke && (cyc == 2);
      num_samples = CW'($urandom_range(1, 3));
      if (in_valid && in_ready) begin
        acc++;
        acc_q.push_back(bt);
        if (stim_q.size() != 0) void'(stim_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_accepts"}, acc, n);
    // Keep offering beats while draining; none may be taken.
    in_valid = 1'b1;
    idx = 1;
    rdy = 0;
    while (!done && idx < 20) begin
      if (in_ready || in_ready_n) rdy++;
      bt = rand_beat();
      op_a = bt.a;
      op_b = bt.b;
      approx_p = bt.p;
      @(negedge clk);
      idx++;
      if (idx == 3 && n > 0) chk({tag, "_lat2_samples"}, sample_cnt, n);
    end
    chk({tag, "_ready_after_last"}, rdy, 0);
    chk({tag, "_done_latency"}, idx, (n == 0) ? 1 : 4);
    chk({tag, "_n_done"}, done_n, 1);
    check_results(tag);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_hold_samples"}, sample_cnt, acc_q.size());
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    num_samples = '0;
    op_a = '0;
    op_b = '0;
    approx_p = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    stim_q.push_back(mk(3, 5, 15));
    stim_q.push_back(mk(-2, 4, -8));
    stim_q.push_back(mk(127, 127, 16000));
    run_batch("t1", 3, 0, 7'h0, 1'b0, 0);
    chk("t1_sum_const", err_sum, 129);
    chk("t1_max_const", err_max, 129);
    chk("t1_cnt_const", err_cnt, 1);

    stim_q.push_back(mk(-128, -128, 16'h8000));
    run_batch("t2", 1, 0, 7'h0, 1'b0, 0);
    chk("t2_max_const", err_max, 49152);
    chk("t2_sum_const", err_sum, 49152);

    stim_q.push_back(mk(-128, -128, 16'h8000));
    stim_q.push_back(mk(-128, -128, 16'h8000));
    run_batch("t3", 2, 0, 7'h0, 1'b0, 0);
    chk("t3_n_sum_const", err_sum_n, 65535);
    chk("t3_n_sat_const", sat_n, 1);
    chk("t3_sum_const", err_sum, 98304);

    run_batch("t4", 4, 2, 7'b1011001, 1'b1, 0);
    run_batch("t5", 0, 0, 7'h0, 1'b0, 0);
    run_batch("t6", 5, 1, 7'h0, 1'b0, 2);
    run_batch("t6b", 1, 0, 7'h0, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      run_batch("rnd", $urandom_range(1, 12), 1, 7'h0, ($urandom_range(0, 1) == 1), 0);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
